// File: rtl/display_update_controller.sv
// Display update controller: converts a 12-bit binary value to four BCD digits
// with a double-dabble engine, then multiplexes the committed digits onto a
// scanned 4-digit display with leading-zero suppression.
module display_update_controller #(
  parameter int unsigned REFRESH_COUNT = 10000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] in_value,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        busy,
  output logic        conv_done,
  output logic [3:0]  digit_value,
  output logic [3:0]  digit_select,
  output logic        digit_blank
);

  localparam int unsigned RW = (REFRESH_COUNT > 1) ? $clog2(REFRESH_COUNT) : 1;
  localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_COUNT - 1);

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    COMMIT
  } state_t;

  state_t        state_q, state_d;
  logic [11:0]   bin_q, bin_d;
  logic [15:0]   bcd_q, bcd_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [15:0]   disp_q, disp_d;
  logic [RW-1:0] refresh_q, refresh_d;
  logic [1:0]    pos_q, pos_d;
  logic [15:0]   bcdAdj;
  logic [3:0]    posDigit;
  logic          posBlank;

  // Double-dabble correction: bump every BCD nibble that would overflow when doubled
  always_comb begin
    bcdAdj = bcd_q;
    for (int i = 0; i < 4; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcdAdj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // Conversion FSM: accept in IDLE, shift twelve times in CONVERT, publish in COMMIT
  always_comb begin
    state_d   = state_q;
    bin_d     = bin_q;
    bcd_d     = bcd_q;
    cnt_d     = cnt_q;
    disp_d    = disp_q;
    in_ready  = 1'b0;
    busy      = 1'b0;
    conv_done = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          bin_d   = in_value;
          bcd_d   = 16'd0;
          cnt_d   = 4'd12;
          state_d = CONVERT;
        end
      end
      CONVERT: begin
        busy           = 1'b1;
        {bcd_d, bin_d} = {bcdAdj, bin_q} << 1;
        cnt_d          = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = COMMIT;
        end
      end
      COMMIT: begin
        busy      = 1'b1;
        conv_done = 1'b1;
        disp_d    = bcd_q;
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Refresh timer and scan position run freely, unaffected by conversions
  always_comb begin
    refresh_d = refresh_q + RW'(1);
    pos_d     = pos_q;
    if (refresh_q == REFRESH_LAST) begin
      refresh_d = '0;
      pos_d     = pos_q + 2'd1;
    end
  end

  // Select the active digit and decide whether it is a suppressed leading zero
  always_comb begin
    posDigit = disp_q[3:0];
    posBlank = 1'b0;
    unique case (pos_q)
      2'd0: begin
        posDigit = disp_q[3:0];
        posBlank = 1'b0;
      end
      2'd1: begin
        posDigit = disp_q[7:4];
        posBlank = (disp_q[15:4] == 12'd0);
      end
      2'd2: begin
        posDigit = disp_q[11:8];
        posBlank = (disp_q[15:8] == 8'd0);
      end
      default: begin
        posDigit = disp_q[15:12];
        posBlank = (disp_q[15:12] == 4'd0);
      end
    endcase
    digit_blank  = posBlank;
    digit_value  = posBlank ? 4'd0 : posDigit;
    digit_select = posBlank ? 4'b1111 : ~(4'b0001 << pos_q);
  end

  // State registers; reset aborts any conversion and clears the display
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      bin_q     <= 12'd0;
      bcd_q     <= 16'd0;
      cnt_q     <= 4'd0;
      disp_q    <= 16'd0;
      refresh_q <= '0;
      pos_q     <= 2'd0;
    end else begin
      state_q   <= state_d;
      bin_q     <= bin_d;
      bcd_q     <= bcd_d;
      cnt_q     <= cnt_d;
      disp_q    <= disp_d;
      refresh_q <= refresh_d;
      pos_q     <= pos_d;
    end
  end

endmodule

// File: tb/tb_display_update_controller.sv
// Scoreboard bench for display_update_controller: the stimulus pushes the
// hand-computed BCD result for every value it offers, and a monitor pops it
// when conv_done appears, then checks the scanned display every cycle.
module tb_display_update_controller;

  localparam int R = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [11:0] in_value = 12'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        busy;
  logic        conv_done;
  logic [3:0]  digit_value;
  logic [3:0]  digit_select;
  logic        digit_blank;

  int          tbCycles;
  logic [15:0] expQ[$];
  int          hsQ[$];
  int          passCount = 0;
  int          checkCount = 0;

  always #5 clk = ~clk;

  display_update_controller #(.REFRESH_COUNT(R)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_value     (in_value),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .busy         (busy),
    .conv_done    (conv_done),
    .digit_value  (digit_value),
    .digit_select (digit_select),
    .digit_blank  (digit_blank)
  );

  task automatic checkOutput(input string name, input int actual, input int expected);
    checkCount++;
    if (actual == expected) passCount++;
    else $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
  endtask

  // Bench copy of the free-running refresh timeline: posedges since reset release
  always @(posedge clk or negedge reset) begin
    if (!reset) tbCycles <= 0;
    else        tbCycles <= tbCycles + 1;
  end

  // Record the cycle index at which each handshake lands
  always @(posedge clk) begin
    if (reset && in_valid && in_ready) hsQ.push_back(tbCycles + 1);
  end

  // Monitor: check handshake/busy timing, pop results on conv_done, check scan output
  initial begin
    logic [15:0] expDisp;
    logic [15:0] pendDisp;
    logic [3:0]  one;
    logic [3:0]  expSel;
    logic [3:0]  dig;
    bit          commitPending;
    bit          expBusy;
    bit          expDone;
    bit          blank;
    int          p;
    expDisp       = 16'd0;
    pendDisp      = 16'd0;
    commitPending = 1'b0;
    one           = 4'b0001;
    forever begin
      @(negedge clk);
      if (!reset) begin
        expDisp       = 16'd0;
        commitPending = 1'b0;
        expQ.delete();
        hsQ.delete();
      end else if (commitPending) begin
        expDisp       = pendDisp;
        commitPending = 1'b0;
      end
      expBusy = (hsQ.size() > 0) && (tbCycles >= hsQ[0]);
      expDone = expBusy && (tbCycles == hsQ[0] + 12);
      checkOutput("busy", busy, expBusy);
      checkOutput("in_ready", in_ready, !expBusy);
      checkOutput("conv_done", conv_done, expDone);
      if (expDone) begin
        void'(hsQ.pop_front());
        if (expQ.size() > 0) begin
          pendDisp      = expQ.pop_front();
          commitPending = 1'b1;
        end
      end
      p   = (tbCycles / R) % 4;
      dig = 4'(expDisp >> (4 * p));
      case (p)
        1:       blank = (expDisp[15:4] == 12'd0);
        2:       blank = (expDisp[15:8] == 8'd0);
        3:       blank = (expDisp[15:12] == 4'd0);
        default: blank = 1'b0;
      endcase
      expSel = blank ? 4'b1111 : ~(one << p);
      checkOutput("digit_select", digit_select, expSel);
      checkOutput("digit_value", digit_value, blank ? 0 : dig);
      checkOutput("digit_blank", digit_blank, blank);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic waitReady(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checkCount++;
      $display("[TB] FAIL wait_ready: got in_ready=0 after 60 cycles, expected 1");
    end
  endtask

  task automatic applyStimulus(input logic [11:0] v, input logic [15:0] expBcd, input bit hold);
    bit ok;
    in_value = v;
    in_valid = 1'b1;
    expQ.push_back(expBcd);
    waitReady(ok);
    @(posedge clk);
    #2;
    if (!hold) in_valid = 1'b0;
  endtask

  initial begin
    int t0;
    int t1;
    repeat (2) @(negedge clk);
    checkOutput("rst in_ready", in_ready, 1);
    checkOutput("rst busy", busy, 0);
    checkOutput("rst conv_done", conv_done, 0);
    checkOutput("rst digit_value", digit_value, 0);
    checkOutput("rst digit_blank", digit_blank, 0);
    checkOutput("rst digit_select", digit_select, 4'b1110);
    @(posedge clk);
    #2 reset = 1'b1;
    idle(40);

    applyStimulus(12'd4095, 16'h4095, 1'b0);
    idle(36);
    applyStimulus(12'd7, 16'h0007, 1'b0);
    idle(36);
    applyStimulus(12'd1005, 16'h1005, 1'b0);
    idle(36);
    applyStimulus(12'd1000, 16'h1000, 1'b0);
    idle(36);
    applyStimulus(12'd90, 16'h0090, 1'b0);
    idle(36);
    applyStimulus(12'd305, 16'h0305, 1'b0);
    idle(36);

    applyStimulus(12'd100, 16'h0100, 1'b1);
    t0 = tbCycles;
    applyStimulus(12'd200, 16'h0200, 1'b0);
    t1 = tbCycles;
    checkOutput("accept_gap", t1 - t0, 14);
    idle(36);

    applyStimulus(12'd4095, 16'h4095, 1'b0);
    repeat (6) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    checkOutput("abort busy", busy, 0);
    checkOutput("abort conv_done", conv_done, 0);
    checkOutput("abort in_ready", in_ready, 1);
    checkOutput("abort digit_value", digit_value, 0);
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    idle(3);
    checkOutput("post_abort in_ready", in_ready, 1);
    idle(30);

    checkOutput("pending_results", expQ.size(), 0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/display_update_controller.md
DISPLAY_UPDATE_CONTROLLER -- requirements
Module: display_update_controller

Interface
REQ-001 Parameter REFRESH_COUNT SHALL be: default 10000; clock cycles each digit position is held; legal range 2..2^20.
REQ-002 clk SHALL be: input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 reset SHALL be: input, 1 bit, asynchronous, active-low (0 = reset).
REQ-004 in_value SHALL be: input, 12 bits, unsigned binary value to display (0..4095).
REQ-005 in_valid SHALL be: input, 1 bit, in_value is valid this cycle.
REQ-006 in_ready SHALL be: output, 1 bit, controller can accept a value this cycle.
REQ-007 busy SHALL be: output, 1 bit, a conversion is in progress.
REQ-008 conv_done SHALL be: output, 1 bit, one-cycle pulse when new digits are committed.
REQ-009 digit_value SHALL be: output, 4 bits, BCD digit for the active position.
REQ-010 digit_select SHALL be: output, 4 bits, active-low one-cold enable (1110 units, 1101 tens, 1011 hundreds, 0111 thousands; 1111 all off).
REQ-011 digit_blank SHALL be: output, 1 bit, active position is a suppressed leading zero.

Function
REQ-012 The FSM SHALL have exactly the states IDLE, CONVERT and COMMIT.
REQ-013 in_ready SHALL be 1 only in IDLE; busy SHALL be 1 only in CONVERT or COMMIT.
REQ-014 Handshake: in_valid=1 and in_ready=1 on a rising edge SHALL capture in_value into a 12-bit shift register, clear the 16-bit BCD accumulator, load the bit counter with 12 and enter CONVERT.
REQ-015 in_value SHALL be sampled only on the handshake edge; in_valid while busy SHALL be ignored with no capture, and the source holds it until in_ready=1.
REQ-016 Each edge in CONVERT SHALL perform one double-dabble step: add 3 to every BCD nibble >= 5, then shift {BCD, binary} left by one bit and decrement the counter.
REQ-017 After the 12th step the FSM SHALL enter COMMIT; conv_done SHALL be 1 for exactly the COMMIT cycle.
REQ-018 The edge leaving COMMIT SHALL load the four display digit registers from the accumulator and return to IDLE.
REQ-019 Latency: handshake edge E0, steps on E1..E12, digit registers updated on E13, next handshake possible no earlier than E14.
REQ-020 Display digit registers SHALL change only on the COMMIT exit edge, so no partial result is ever shown.
REQ-021 The refresh counter SHALL count 0..REFRESH_COUNT-1 and wrap to 0; on the wrap edge the scan position SHALL advance 0->1->2->3->0.
REQ-022 Scanning SHALL be independent of the FSM and never stall during conversion.
REQ-023 Thousands SHALL be blanked when it is 0; hundreds when thousands and hundreds are 0; tens when thousands, hundreds and tens are 0; units SHALL never be blanked.
REQ-024 For a blanked position: digit_blank=1, digit_select=1111, digit_value=0. Otherwise digit_blank=0, digit_select per REQ-010, and digit_value equals that position's stored digit.
REQ-025 Every committed digit SHALL be in 0..9.

Reset
REQ-026 reset=0 SHALL immediately force: state IDLE, shift register, accumulator and counter 0, display digits 0, scan position 0, refresh counter 0.
REQ-027 During and after reset until the first handshake: in_ready=1, busy=0, conv_done=0, digit_value=0, digit_blank=0 at position 0.
REQ-028 Reset asserted mid-conversion SHALL abort the conversion with no conv_done pulse; the display shows 0 after release.

Verification
REQ-029 Reset release, no input: position 0 -> select 1110, value 0; positions 1..3 -> select 1111, blank 1; each position held REFRESH_COUNT cycles.
REQ-030 Handshake with in_value=4095: conv_done exactly during the cycle before E13; digits units..thousands = 5,9,0,4; no blanking.
REQ-031 in_value=7: units=7 shown; tens, hundreds and thousands blanked (select 1111).
REQ-032 in_value=1005: digits 5,0,0,1; tens and hundreds shown as 0, not blanked.
REQ-033 in_valid held with 100 at E0, then 200 during busy: 200 is ignored until in_ready=1; 200 is accepted at E14 and its conv_done comes 13 edges later.
REQ-034 Accept 4095, then pull reset low after the E6 step: busy=0 and no conv_done; after release digits read 0 and in_ready=1.
